// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, bit-period helper and frame constants.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

   localparam int unsigned DataBits = 8;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_e;
`else
   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StData,
      StStop
   } tx_state_e;
`endif

   // Clock cycles per serial bit, truncated; callers must guarantee a result >= 2.
   function automatic int unsigned bit_period(input int unsigned freq, input int unsigned baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count; pushes when full and pops when
// empty are ignored. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == FullCount);
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage is not reset; the count alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small FIFO with valid/ready input handshake.
// Defining UART_TX_PARITY_EN adds an even-parity bit between data and stop bits.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned BAUDRATE   = 115200,
   parameter int unsigned FREQ       = 50_000_000,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic [7:0]                    DATA_IN,
   input  logic                          VALID_IN,
   output logic                          READY_OUT,
   output logic                          TX,
   output logic                          BUSY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

   localparam int unsigned T  = bit_period(FREQ, BAUDRATE);
   localparam int unsigned CW = $clog2(T);
   localparam logic [CW-1:0] CntLast = CW'(T - 1);
   localparam logic [2:0]    BitLast = 3'(DataBits - 1);

   tx_state_e           state_q, state_d;
   logic [CW-1:0]       cnt_clk_q, cnt_clk_d;
   logic [2:0]          cnt_bit_q, cnt_bit_d;
   logic [DataBits-1:0] shift_q, shift_d;
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                bit_end;
   logic                load;
   logic [DataBits-1:0] fifo_data;
   logic                fifo_full;
   logic                fifo_empty;
`ifdef UART_TX_PARITY_EN
   logic                parity_q, parity_d;
`endif

   sync_fifo #(
      .WIDTH (DataBits),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .reset     (RESET),
      .push      (VALID_IN),
      .push_data (DATA_IN),
      .pop       (load),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (FIFO_COUNT)
   );

   assign READY_OUT = ~fifo_full;
   assign TX        = tx_q;
   assign BUSY      = busy_q;
   assign bit_end   = (cnt_clk_q == CntLast);

   // State register; TX and BUSY are registered from the current state so they
   // change together, one cycle behind the state.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= StIdle;
         cnt_clk_q <= '0;
         cnt_bit_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_clk_q <= cnt_clk_d;
         cnt_bit_q <= cnt_bit_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_clk_d = cnt_clk_q;
      cnt_bit_d = cnt_bit_q;
      shift_d   = shift_q;
      load      = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      unique case (state_q)
         StIdle: load = ~fifo_empty;
         StStart: begin
            if (bit_end) begin
               cnt_clk_d = '0;
               cnt_bit_d = '0;
               state_d   = StData;
            end else begin
               cnt_clk_d = cnt_clk_q + 1'b1;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_clk_d = '0;
               shift_d   = shift_q >> 1;
               if (cnt_bit_q == BitLast) begin
                  cnt_bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = StParity;
`else
                  state_d   = StStop;
`endif
               end else begin
                  cnt_bit_d = cnt_bit_q + 1'b1;
               end
            end else begin
               cnt_clk_d = cnt_clk_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               cnt_clk_d = '0;
               state_d   = StStop;
            end else begin
               cnt_clk_d = cnt_clk_q + 1'b1;
            end
         end
`endif
         StStop: begin
            if (bit_end) begin
               cnt_clk_d = '0;
               // Chain straight into the next start bit when more data is queued.
               if (fifo_empty) state_d = StIdle;
               else            load    = 1'b1;
            end else begin
               cnt_clk_d = cnt_clk_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         state_d = StStart;
         shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
         parity_d = ^fifo_data;
`endif
      end
   end

   always_comb begin
      tx_d = 1'b1;
      unique case (state_q)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_q;
`endif
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_q != StIdle);
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed stimulus, byte scoreboard and a
// serial-line monitor that decodes frames mid-bit.
module tb_uart_tx_fifo;

   localparam int unsigned FREQ  = 1_000_000;
   localparam int unsigned BAUD  = 100_000;
   localparam int unsigned DEPTH = 4;
   localparam int          T     = 10;
`ifdef UART_TX_PARITY_EN
   localparam int          NB    = 11;
`else
   localparam int          NB    = 10;
`endif

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] DATA_IN = 8'h00;
   logic       VALID_IN = 1'b0;
   logic       READY_OUT;
   logic       TX;
   logic       BUSY;
   logic [2:0] FIFO_COUNT;

   int         checks = 0;
   int         failures = 0;
   int         frames = 0;
   logic [7:0] exp_q[$];

   uart_tx_fifo #(
      .BAUDRATE   (BAUD),
      .FREQ       (FREQ),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .DATA_IN    (DATA_IN),
      .VALID_IN   (VALID_IN),
      .READY_OUT  (READY_OUT),
      .TX         (TX),
      .BUSY       (BUSY),
      .FIFO_COUNT (FIFO_COUNT)
   );

   initial forever #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_burst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] bytes [3];
      bytes[0] = b0;
      bytes[1] = b1;
      bytes[2] = b2;
      VALID_IN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         DATA_IN = bytes[i];
         check("burst_ready", READY_OUT, 1);
         exp_q.push_back(bytes[i]);
         tick();
      end
      VALID_IN = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (n < 3000 && !(BUSY === 1'b0 && FIFO_COUNT === 3'd0 && exp_q.size() == 0)) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_idle"}, BUSY, 0);
      repeat (3) tick();
   endtask

   task automatic busy_span(input string tag, input int expected);
      int n = 0;
      for (int i = 0; i < 500; i++) begin
         if (BUSY === 1'b1) n++;
         else if (n > 0) break;
         tick();
      end
      check(tag, n, expected);
   endtask

   // Line monitor: sample each bit in its middle and score completed frames.
   initial begin : monitor
      bit         active;
      int         cnt;
      int         idx;
      logic [7:0] byte_v;
      logic [7:0] exp_b;
`ifdef UART_TX_PARITY_EN
      logic       par_v;
`endif
      active = 1'b0;
      cnt    = 0;
      byte_v = 8'h00;
      forever begin
         @(negedge CLK);
         if (RESET) begin
            active = 1'b0;
         end else if (!active) begin
            if (TX === 1'b0) begin
               active = 1'b1;
               cnt    = 0;
            end
         end else begin
            cnt++;
            if (cnt % T == T / 2) begin
               idx = cnt / T;
               if (idx == 0) begin
                  check("start_bit", TX, 0);
               end else if (idx <= 8) begin
                  byte_v[idx-1] = TX;
`ifdef UART_TX_PARITY_EN
               end else if (idx == 9) begin
                  par_v = TX;
`endif
               end else begin
                  check("stop_bit", TX, 1);
                  if (exp_q.size() == 0) begin
                     check("frame_expected", exp_q.size(), 1);
                  end else begin
                     exp_b = exp_q.pop_front();
                     check("frame_byte", byte_v, exp_b);
`ifdef UART_TX_PARITY_EN
                     check("parity_bit", par_v, ^exp_b);
`endif
                  end
                  frames++;
                  active = 1'b0;
               end
            end
         end
      end
   end

   initial begin : stimulus
      int f0;
      repeat (3) tick();
      check("rst_tx", TX, 1);
      check("rst_busy", BUSY, 0);
      check("rst_ready", READY_OUT, 1);
      check("rst_count", FIFO_COUNT, 0);
      RESET = 1'b0;
      tick();

      // Single byte 0x55: exact start, data and stop timing.
      f0 = frames;
      VALID_IN = 1'b1;
      DATA_IN  = 8'h55;
      check("t1_ready", READY_OUT, 1);
      exp_q.push_back(8'h55);
      tick();                                   // edge 0
      VALID_IN = 1'b0;
      check("t1_count_e0", FIFO_COUNT, 1);
      check("t1_tx_e0", TX, 1);
      tick();                                   // edge 1
      check("t1_count_e1", FIFO_COUNT, 0);
      check("t1_tx_e1", TX, 1);
      check("t1_busy_e1", BUSY, 0);
      tick();                                   // edge 2
      check("t1_tx_start", TX, 0);
      check("t1_busy_e2", BUSY, 1);
      repeat (9) tick();                        // edge 11
      check("t1_tx_start_end", TX, 0);
      tick();                                   // edge 12
      check("t1_tx_bit0", TX, 1);
      repeat (10) tick();                       // edge 22
      check("t1_tx_bit1", TX, 0);
      repeat (69) tick();                       // edge 91
      check("t1_tx_bit7", TX, 0);
      tick();                                   // edge 92
      check("t1_tx_stop", TX, 1);
      repeat (9) tick();                        // edge 101
      check("t1_busy_e101", BUSY, 1);
      tick();                                   // edge 102
      check("t1_busy_e102", BUSY, 0);
      check("t1_tx_idle", TX, 1);
      wait_idle("t1");
      check("t1_frames", frames - f0, 1);

      // Three back-to-back bytes: continuous BUSY for exactly 3 frames.
      f0 = frames;
      push_burst(8'hA3, 8'h00, 8'hFF);
      busy_span("t2_busy_cycles", 3 * NB * T);
      wait_idle("t2");
      check("t2_frames", frames - f0, 3);

      // VALID held with 8 distinct bytes: only the first 5 fit (1 popped, 4 stored).
      f0 = frames;
      VALID_IN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         DATA_IN = 8'h30 + 8'(i);
         check("t3_ready", READY_OUT, (i < 5) ? 1 : 0);
         if (i < 5) exp_q.push_back(8'h30 + 8'(i));
         tick();
      end
      VALID_IN = 1'b0;
      check("t3_count_full", FIFO_COUNT, 4);
      check("t3_ready_full", READY_OUT, 0);
      wait_idle("t3");
      check("t3_frames", frames - f0, 5);

      // Push coinciding with the end-of-stop pop keeps the count at 2.
      f0 = frames;
      push_burst(8'hC6, 8'h19, 8'h7E);          // now after edge 2
      repeat (98) tick();                       // edge 100
      check("t4_count_pre", FIFO_COUNT, 2);
      VALID_IN = 1'b1;
      DATA_IN  = 8'hE1;
      exp_q.push_back(8'hE1);
      tick();                                   // edge 101: push and pop
      VALID_IN = 1'b0;
      check("t4_count_same", FIFO_COUNT, 2);
      check("t4_ready_same", READY_OUT, 1);
      tick();                                   // edge 102
      check("t4_b2b_start", TX, 0);
      wait_idle("t4");
      check("t4_frames", frames - f0, 4);

      // Reset during data bit 3 aborts the frame and flushes the FIFO.
      push_burst(8'h5A, 8'h11, 8'h22);          // now after edge 2
      repeat (42) tick();                       // edge 44
      check("t5_tx_bit3", TX, 1);
      check("t5_busy_mid", BUSY, 1);
      RESET = 1'b1;
      exp_q.delete();
      tick();                                   // edge 45
      RESET = 1'b0;
      check("t5_rst_tx", TX, 1);
      check("t5_rst_busy", BUSY, 0);
      check("t5_rst_count", FIFO_COUNT, 0);
      check("t5_rst_ready", READY_OUT, 1);
      repeat (20) tick();
      check("t5_quiet_tx", TX, 1);
      check("t5_quiet_busy", BUSY, 0);
      f0 = frames;
      VALID_IN = 1'b1;
      DATA_IN  = 8'h3C;
      exp_q.push_back(8'h3C);
      tick();
      VALID_IN = 1'b0;
      wait_idle("t5");
      check("t5_frames", frames - f0, 1);

`ifdef UART_TX_PARITY_EN
      // Parity: 0x07 has odd weight (parity 1), 0x03 even weight (parity 0).
      f0 = frames;
      VALID_IN = 1'b1;
      DATA_IN  = 8'h07;
      exp_q.push_back(8'h07);
      tick();
      VALID_IN = 1'b0;
      busy_span("t6_frame_len", 110);
      wait_idle("t6a");
      VALID_IN = 1'b1;
      DATA_IN  = 8'h03;
      exp_q.push_back(8'h03);
      tick();
      VALID_IN = 1'b0;
      wait_idle("t6b");
      check("t6_frames", frames - f0, 2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter with a small input FIFO. It serialises bytes as 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
- It is the transmit-side counterpart of the UART receive path and shares its BAUDRATE/FREQ conventions. The default is a 50 MHz system clock at 115200 baud.
- Upstream logic pushes bytes with a valid/ready handshake. The FIFO decouples bursty producers from the serial line.

Parameters:
- BAUDRATE, 115200, line bit rate.
- FREQ, 50_000_000, CLK frequency in Hz. Bit period T = FREQ / BAUDRATE, integer-truncated. T >= 2 is required.
- FIFO_DEPTH, 16, FIFO entries. Must be a power of 2 and >= 2.

Ports:
- CLK  in  1  system clock. The block uses this one clock only.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  8  byte to send.
- VALID_IN  in  1  DATA_IN is valid.
- READY_OUT  out  1  FIFO can accept a byte.
- TX  out  1  serial line; idles high.
- BUSY  out  1  a frame is in progress.
- FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  number of stored bytes.

Behaviour:
- Reset values: TX=1, BUSY=0, READY_OUT=1, FIFO_COUNT=0. State=IDLE; all counters 0.
- Reset mid-frame aborts the frame. TX is high on the cycle after RESET is sampled, and FIFO contents are discarded.
- Handshake:
  - A byte is accepted on a rising CLK edge with VALID_IN && READY_OUT.
  - READY_OUT = (FIFO_COUNT != FIFO_DEPTH). It is driven from registered count only, with no combinational path from VALID_IN.
  - VALID_IN while full is ignored and the byte is dropped.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - Push and pop in the same cycle leave the count unchanged.
  - A push into an empty FIFO is not poppable until the next cycle.
- FSM states: IDLE, START, DATA, STOP. A bit counter cnt_clk runs 0..T-1, and a data index cnt_bit runs 0..7.
- IDLE: TX=1. If FIFO_COUNT != 0, pop into the shift register and go to START.
- START: TX=0 for T cycles, then go to DATA.
- DATA: TX = shift[0] for T cycles per bit. Shift right at the end of each bit. After bit 7 completes, go to STOP.
- STOP: TX=1 for T cycles. At the end of STOP:
  - if the FIFO is non-empty, pop and go directly to START, so there is no idle gap between frames;
  - otherwise go to IDLE.
- TX is a registered output.
- Latency: byte pushed at edge n into an idle, empty block → count=1 after edge n → pop at edge n+1 → TX low from edge n+2.
- Frame length: exactly 10*T cycles. Back-to-back frames total exactly k*10*T cycles.
- BUSY = (state != IDLE), registered with the state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for T cycles, making the frame 11*T cycles.
- Undefined: 8N1 with no PARITY state or logic.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, [PARITY], STOP);
  - a constant function for bit period T from FREQ/BAUDRATE;
  - localparams for frame bit counts.
- Sub-module sync_fifo (parameterised width/depth; push, pop, full, empty, count) is natural. uart_tx_fifo instantiates it with width 8.

Test Plan (FREQ=1_000_000, BAUDRATE=100_000, T=10, FIFO_DEPTH=4):
- Single byte 0x55 pushed at cycle 0 → TX low at cycle 2 for 10 cycles. Data bits then follow LSB first: 1,0,1,0,1,0,1,0, each held 10 cycles. Stop high for 10 cycles, then BUSY=0 at cycle 102.
- Three bytes 0xA3, 0x00, 0xFF pushed on consecutive cycles → three frames sampled mid-bit decode back in order. Total 300 cycles of BUSY=1, with no high gap longer than the stop bit.
- VALID_IN held with 8 distinct bytes from idle → READY_OUT falls once FIFO_COUNT=4. Only accepted bytes (READY_OUT high at the edge) are transmitted, in order; dropped bytes never appear on TX.
- Push and pop in the same cycle (push at end of STOP with count=2) → FIFO_COUNT stays 2 and READY_OUT stays high.
- RESET asserted during DATA bit 3 → the next cycle shows TX=1, BUSY=0, FIFO_COUNT=0, READY_OUT=1. A subsequent push of 0x3C transmits correctly.
- With UART_TX_PARITY_EN, byte 0x07 → parity bit 1 and a frame of 110 cycles. Byte 0x03 → parity bit 0.
